// File: rtl/mvm_drv_pkg.sv
// mvm_drv_pkg: shared states and constants for the MVM host driver.
package mvm_drv_pkg;
  typedef enum logic [3:0] {
    IDLE,
    FILL,
    LOAD_M,
    GAP_M,
    LOAD_V,
    GAP_V,
    START,
    WAIT_DONE,
    CAPTURE,
    DRAIN
  } state_t;
  localparam int GAP_CYCLES = 1;
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_NO_MATRIX = 1;
endpackage

// File: rtl/mvm_drv_buf.sv
// mvm_drv_buf: single-port register file with synchronous read, holds one input frame.
module mvm_drv_buf #(
  parameter int depth = 20,
  parameter int width = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] addr,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata
);
  logic [width-1:0] mem [depth];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mvm_host_driver.sv
// mvm_host_driver: buffers a frame, replays it as MVM load/start bursts, drains the k results.
module mvm_host_driver
  import mvm_drv_pkg::*;
#(
  parameter int k       = 4,
  parameter int b       = 8,
  parameter int TIMEOUT = 256
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [b-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_vec_only,
  output logic           mvm_loadMatrix,
  output logic           mvm_loadVector,
  output logic           mvm_start,
  output logic [b-1:0]   mvm_data_in,
  input  logic           mvm_done,
  input  logic [2*b-1:0] mvm_data_out,
  output logic [2*b-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           busy,
  output logic [1:0]     err
);
  localparam int KK = k * k;
  localparam int N  = KK + k;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(k);
  localparam int CW = $clog2(TIMEOUT + N + 1) + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] wr_ptr, buf_addr;
  logic [b-1:0] rd_data;
  logic started, vec_only, matrix_loaded, hs_in;
  logic [2*b-1:0] res [k];
  assign hs_in = in_ready & in_valid;
  assign busy = state != IDLE;
  // Vector words always live at offset KK, so a vec-only frame reuses the same read path.
  assign buf_addr = state == IDLE   ? (in_vec_only ? AW'(KK) : '0) :
                    state == FILL   ? wr_ptr :
                    state == LOAD_V ? AW'(KK) + cnt[AW-1:0] : cnt[AW-1:0];
  mvm_drv_buf #(.depth(N), .width(b)) u_buf (
    .clk(clk),
    .we(hs_in),
    .addr(buf_addr),
    .wdata(in_data),
    .rdata(rd_data)
  );
  always_comb begin
    state_n = state;
    in_ready = 1'b0;
    mvm_loadMatrix = 1'b0;
    mvm_loadVector = 1'b0;
    mvm_start = 1'b0;
    mvm_data_in = '0;
    out_valid = 1'b0;
    out_data = '0;
    out_last = 1'b0;
    case (state)
      IDLE: begin
        in_ready = started;
        if (started && in_valid) state_n = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && wr_ptr == AW'(N - 1)) state_n = vec_only ? LOAD_V : LOAD_M;
      end
      LOAD_M: begin
        mvm_loadMatrix = cnt == '0;
        mvm_data_in = cnt != '0 ? rd_data : '0;
        if (cnt == CW'(KK)) state_n = GAP_M;
      end
      GAP_M: if (cnt == CW'(GAP_CYCLES - 1)) state_n = LOAD_V;
      LOAD_V: begin
        mvm_loadVector = cnt == '0;
        mvm_data_in = cnt != '0 ? rd_data : '0;
        if (cnt == CW'(k)) state_n = GAP_V;
      end
      GAP_V: if (cnt == CW'(GAP_CYCLES - 1)) state_n = START;
      START: begin
        mvm_start = 1'b1;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: state_n = mvm_done ? CAPTURE : cnt == CW'(TIMEOUT) ? IDLE : WAIT_DONE;
      CAPTURE: if (cnt == CW'(k - 1)) state_n = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        out_data = res[cnt[RW-1:0]];
        out_last = cnt == CW'(k - 1);
        if (out_ready && out_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // WAIT_DONE starts at 1 so cnt equals cycles elapsed since the start pulse.
    cnt_n = state_n != state ? CW'(state == START) :
            (state == IDLE || state == FILL) ? '0 :
            state == DRAIN ? cnt + CW'(out_ready) : cnt + 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      wr_ptr <= '0;
      started <= 1'b0;
      vec_only <= 1'b0;
      matrix_loaded <= 1'b0;
      err <= '0;
      for (int i = 0; i < k; i++) res[i] <= '0;
    end else begin
      started <= 1'b1;
      state <= state_n;
      cnt <= cnt_n;
      if (hs_in) wr_ptr <= buf_addr + 1'b1;
      if (hs_in && state == IDLE) begin
        vec_only <= in_vec_only;
        if (in_vec_only && !matrix_loaded) err[ERR_NO_MATRIX] <= 1'b1;
      end
      if (state == LOAD_M) matrix_loaded <= 1'b1;
      if (state == WAIT_DONE && !mvm_done && cnt == CW'(TIMEOUT)) err[ERR_TIMEOUT] <= 1'b1;
      if (state == CAPTURE) res[cnt[RW-1:0]] <= mvm_data_out;
    end
  end
endmodule

// File: tb/tb_mvm_host_driver.sv
// tb_mvm_host_driver: directed bench with a behavioural 4x4 MVM core model.
module tb_mvm_host_driver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_vec_only = 1'b0;
  logic in_ready;
  logic mvm_loadMatrix, mvm_loadVector, mvm_start;
  logic [7:0] mvm_data_in;
  logic mvm_done = 1'b0;
  logic [15:0] mvm_data_out = '0;
  logic [15:0] out_data;
  logic out_valid, out_last, busy;
  logic out_ready = 1'b0;
  logic [1:0] err;
  int checks = 0;
  int errors = 0;
  logic [7:0] frame [20];
  logic [15:0] expv [4];
  int cyc = 0, last_hs = 0, lm_cyc = 0, st_cyc = 0, lm_count = 0, ov_count = 0;
  bit done_en = 1'b1;
  logic signed [7:0] ma [16];
  logic signed [7:0] mx [4];
  logic signed [15:0] my [4];
  int mph = 0, vph = 0, wt = -1, oi = -1;

  mvm_host_driver #(.k(4), .b(8), .TIMEOUT(256)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_vec_only(in_vec_only),
    .mvm_loadMatrix(mvm_loadMatrix),
    .mvm_loadVector(mvm_loadVector),
    .mvm_start(mvm_start),
    .mvm_data_in(mvm_data_in),
    .mvm_done(mvm_done),
    .mvm_data_out(mvm_data_out),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) last_hs = cyc;
    if (mvm_loadMatrix) begin
      lm_cyc = cyc;
      lm_count++;
    end
    if (mvm_start) st_cyc = cyc;
    if (out_valid) ov_count++;
    cyc++;
  end

  // MVM model: captures bursts after each load pulse, answers 3 cycles after start.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mph = 0;
      vph = 0;
      wt = -1;
      oi = -1;
      for (int i = 0; i < 16; i++) ma[i] = '0;
      for (int i = 0; i < 4; i++) mx[i] = '0;
      mvm_done <= 1'b0;
      mvm_data_out <= '0;
    end else begin
      mvm_done <= 1'b0;
      if (mph > 0) begin
        ma[16-mph] = mvm_data_in;
        mph--;
      end
      if (vph > 0) begin
        mx[4-vph] = mvm_data_in;
        vph--;
      end
      if (mvm_loadMatrix) mph = 16;
      if (mvm_loadVector) vph = 4;
      if (oi >= 0) begin
        mvm_data_out <= my[oi];
        oi = (oi == 3) ? -1 : oi + 1;
      end
      if (wt > 0) wt--;
      else if (wt == 0) begin
        if (done_en) begin
          mvm_done <= 1'b1;
          for (int r = 0; r < 4; r++) begin
            my[r] = '0;
            for (int j = 0; j < 4; j++) my[r] += ma[r*4+j] * mx[j];
          end
          oi = 0;
        end
        wt = -1;
      end
      if (mvm_start) wt = 3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_full(input int base);
    for (int i = 0; i < 16; i++) frame[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
    for (int j = 0; j < 4; j++) frame[16+j] = 8'(base + j);
  endtask

  task automatic load_vec(input int base);
    for (int j = 0; j < 4; j++) frame[j] = 8'(base + j);
  endtask

  task automatic send_frame(input bit vo, input int n, input bit tog);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      in_data = frame[i];
      in_vec_only = vo;
      in_valid = 1'b1;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (tog && i != n - 1) @(negedge clk);
    end
  endtask

  task automatic drain(input int stall_r);
    for (int r = 0; r < 4; r++) begin
      int t = 0;
      while (!out_valid && t < 400) begin
        @(negedge clk);
        t++;
      end
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_data", 32'(out_data), 32'(expv[r]));
      chk("out_last", 32'(out_last), 32'(r == 3));
      if (r == stall_r) begin
        repeat (10) @(negedge clk);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(expv[r]));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    int t;
    int ov0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pulses", 32'({mvm_loadMatrix, mvm_loadVector, mvm_start}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    #1;
    chk("in_ready_pre_clk", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    // Full frame, identity matrix, x = 1..4
    load_full(1);
    send_frame(1'b0, 20, 1'b0);
    expv = '{16'd1, 16'd2, 16'd3, 16'd4};
    drain(-1);
    chk("lat_loadm", 32'(lm_cyc - last_hs), 32'd1);
    chk("lat_start", 32'(st_cyc - last_hs), 32'd25);
    chk("lm_count1", 32'(lm_count), 32'd1);
    chk("err_f1", 32'(err), 32'd0);
    chk("busy_f1", 32'(busy), 32'd0);
    // Same frame with in_valid toggling 1010
    send_frame(1'b0, 20, 1'b1);
    drain(-1);
    chk("lat_loadm_tog", 32'(lm_cyc - last_hs), 32'd1);
    chk("lat_start_tog", 32'(st_cyc - last_hs), 32'd25);
    chk("lm_count2", 32'(lm_count), 32'd2);
    // Vector-only frame reusing the loaded matrix, with a 10-cycle output stall
    load_vec(5);
    send_frame(1'b1, 4, 1'b0);
    expv = '{16'd5, 16'd6, 16'd7, 16'd8};
    drain(1);
    chk("lat_start_vo", 32'(st_cyc - last_hs), 32'd7);
    chk("lm_count_vo", 32'(lm_count), 32'd2);
    chk("err_vo", 32'(err), 32'd0);
    // Done never arrives
    done_en = 1'b0;
    load_vec(9);
    ov0 = ov_count;
    send_frame(1'b1, 4, 1'b0);
    t = 0;
    while (!mvm_start && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("to_start_seen", 32'(mvm_start), 32'd1);
    repeat (255) @(negedge clk);
    chk("to_err_early", 32'(err), 32'd0);
    chk("to_busy_wait", 32'(busy), 32'd1);
    t = 0;
    while (!err[0] && t < 5) begin
      @(negedge clk);
      t++;
    end
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_no_output", 32'(ov_count - ov0), 32'd0);
    done_en = 1'b1;
    // Reset in the middle of the matrix burst
    load_full(1);
    send_frame(1'b0, 20, 1'b0);
    chk("lm_pulse", 32'(mvm_loadMatrix), 32'd1);
    chk("lm_cycle0_data", 32'(mvm_data_in), 32'd0);
    @(negedge clk);
    chk("burst_word0", 32'(mvm_data_in), 32'd1);
    @(negedge clk);
    chk("burst_word1", 32'(mvm_data_in), 32'd0);
    repeat (4) @(negedge clk);
    chk("burst_word5", 32'(mvm_data_in), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_data", 32'(mvm_data_in), 32'd0);
    chk("mid_rst_pulses", 32'({mvm_loadMatrix, mvm_loadVector, mvm_start}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_out", 32'({out_valid, out_last, out_data}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // Vector-only frame with no matrix loaded since reset
    load_vec(5);
    send_frame(1'b1, 4, 1'b0);
    expv = '{16'd0, 16'd0, 16'd0, 16'd0};
    drain(-1);
    chk("nomat_err", 32'(err), 32'd2);
    chk("nomat_lm_count", 32'(lm_count), 32'd3);
    chk("nomat_busy", 32'(busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
